// File: rtl/timer_load_ctrl_pkg.sv
// Shared encodings for the interval-timer sequencer and its counter core.
package timer_load_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_load_ctrl_load_counter_core.sv
// Loadable up-counter: load beats enable, holds when both are low.
module load_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_load_ctrl.sv
// Interval timer: drives the counter core's load/en from a config/start/stop FSM
// and emits a registered tick at each terminal count.
module timer_load_ctrl
  import timer_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_reload,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_tick;
  logic             w_load;
  logic             w_en;
  logic             w_tick_next;
  logic             w_cfg_fire;
  logic             w_at_max;
  logic [WIDTH-1:0] w_count;

  assign w_cfg_fire = cfg_valid && (r_state == IDLE);
  assign w_at_max   = (w_count == MAX);

  // Next state and counter-core drive.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_tick_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = LOAD;
      end
      LOAD: begin
        if (stop) begin
          w_next_state = IDLE;
        end else begin
          w_load       = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_next_state = IDLE;
        end else if (!w_at_max) begin
          w_en = 1'b1;
        end else begin
          w_tick_next = 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            w_load = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tick  <= w_tick_next;
    end
  end

  // Config is captured in the same edge as start so a colliding start uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload <= '0;
      r_mode   <= MODE_ONESHOT;
    end else if (w_cfg_fire) begin
      r_reload <= cfg_reload;
      r_mode   <= cfg_mode;
    end
  end

  load_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .en     (w_en),
    .data_in(r_reload),
    .count  (w_count)
  );

  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state == LOAD) || (r_state == RUN);
  assign done      = (r_state == DONE);
  assign tick      = r_tick;
  assign count     = w_count;

endmodule
